wptr_full_lvl: RTL and testbench
================================

# wptr_full_lvl

Write-domain pointer and status block for the team's dual-clock FIFOs. It is a parametrised successor to the basic write-pointer/full generator. It keeps the binary write address and Gray-coded write pointer, and produces a registered full flag from the already-synchronised Gray read pointer. It adds a registered fill level, a programmable almost-full flag, a sticky overflow flag and a write-accept strobe. It sits between the TX/RX write client and the FIFO memory, and feeds `wptr` to the read-domain synchroniser.

## Interface
- `ASIZE`, default 4: address width; depth = 2^ASIZE; legal range 1..12.
- `wrt_clk`  in  1: write clock; the only clock in the block.
- `wrst`  in  1: reset, synchronous and active-high.
- `wrt_en`  in  1: write request.
- `s_rptr`  in  ASIZE+1: Gray read pointer, already synchronised into `wrt_clk`.
- `af_thresh`  in  ASIZE+1: almost-full threshold, in words (0..2^ASIZE).
- `ovf_clr`  in  1: clears `woverflow`.
- `wrt_acc`  out  1: write accepted this cycle (combinational).
- `waddr`  out  ASIZE: memory write address.
- `wptr`  out  ASIZE+1: registered Gray write pointer.
- `wfull`  out  1: registered full flag.
- `walmost_full`  out  1: registered almost-full flag.
- `wlevel`  out  ASIZE+1: registered fill level, 0..2^ASIZE.
- `woverflow`  out  1: sticky overflow flag.

## Operation
- `wrt_acc = wrt_en & ~wfull`. The memory write strobe is `wrt_acc`, and the data goes to `waddr`.
- Internal binary pointer `bin` is ASIZE+1 bits. `bnext = bin + wrt_acc`, with modulo 2^(ASIZE+1) wrap. `gnext = bnext ^ (bnext >> 1)`.
- `waddr = bin[ASIZE-1:0]`, so the address wraps naturally from 2^ASIZE-1 to 0.
- `rbin = gray2bin(s_rptr)`, computed combinationally.
- `lvl_next = (bnext - rbin)` mod 2^(ASIZE+1). The result is always in 0..2^ASIZE.
- On each edge, when `wrst` = 0:
  - `bin <= bnext`, `wptr <= gnext`, `wlevel <= lvl_next`.
  - `wfull <= (lvl_next == 2^ASIZE)`. This must be identical to the Gray compare `gnext == {~s_rptr[MSB:MSB-1], s_rptr[rest]}`.
  - `walmost_full <= (lvl_next >= af_thresh)`. With `af_thresh` = 0 the flag is always 1 after the first post-reset edge. With `af_thresh` = 2^ASIZE it equals `wfull`.
  - `woverflow <= (woverflow & ~ovf_clr) | (wrt_en & wfull)`. If set and clear happen in the same cycle, set wins.
- A write while full is dropped: pointer, address and level are unchanged.
- The level is pessimistic because `s_rptr` lags the true read pointer. It can only overestimate, never underestimate.
- `s_rptr` is trusted to change by at most one Gray step per synchroniser sample. The block does no checking.
- `af_thresh` is sampled every cycle and may change at any time; it takes effect on the next edge.

## Timing
- Reset (`wrst` = 1 at an edge):
  - `bin`, `wptr`, `waddr`, `wlevel`, `wfull`, `walmost_full` and `woverflow` all go to 0 on that edge.
  - `wrt_acc` follows `wfull`, so it is 1 whenever `wrt_en` = 1 after reset.
- Reset mid-operation discards all state. Reset has priority over `wrt_en` and `ovf_clr`.
- Write latency: a write accepted at edge k updates `waddr`, `wptr` and `wlevel` at edge k. The write that fills the FIFO asserts `wfull` at that same edge, so there is no extra accept.
- Read release: an `s_rptr` change visible before edge k updates `wlevel`, `wfull` and `walmost_full` at edge k (one cycle).
- Simultaneous write and read advance: the level is unchanged and `wfull` is evaluated on the combined result.
- Combinational path: only `wrt_en` -> `wrt_acc`. All other outputs are registered.

## Structure
- Shared package `fifo_pkg`:
  - functions `bin2gray` and `gray2bin`, parametrised by width;
  - constant `DEPTH = 1 << ASIZE`, derived per instance.
- One sub-module, `gray2bin_conv`: a purely combinational XOR-prefix Gray-to-binary converter of width ASIZE+1. The read-side `rptr_empty_lvl` block reuses it.
- Target size: about 150 lines of RTL including the sub-module.

## Test plan
- Fill: ASIZE=4, reset, `s_rptr`=0, 16 consecutive writes.
  - `wfull` rises at the 16th write edge.
  - `wlevel`=16, `waddr`=0, `wptr`=5'b11000.
  - A 17th `wrt_en` gives `wrt_acc`=0.
- Overflow: from full, hold `wrt_en` for 3 cycles.
  - `woverflow`=1 and the pointer is unchanged.
  - `ovf_clr` alone clears the flag.
  - `ovf_clr` asserted together with another write-while-full leaves `woverflow`=1.
- Almost-full: `af_thresh`=12.
  - After 11 writes `walmost_full`=0; after 12 writes it is 1.
  - Changing `af_thresh` to 13 clears it at the next edge.
- Read release: from full, set `s_rptr`=5'b00110 (binary 4).
  - Next edge: `wfull`=0, `wlevel`=12, `walmost_full` per threshold.
- Wrap: drive `bin` from 31 to 0 with `s_rptr`=gray(20)=5'b11110.
  - `wlevel`=12, `waddr`=0.
  - `wfull` stays 0, and the Gray and level full checks agree on all 32x32 pointer pairs (random sweep with an assertion).
- Reset mid-operation: `wlevel`=9 and `woverflow`=1, assert `wrst` for one edge together with `wrt_en`.
  - All outputs go to 0 on that edge, and no write is accepted.

Source files
------------

// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared helpers for the dual-clock FIFO pointer blocks.
//   ptr_t      : widest pointer any FIFO instance can use (ASIZE up to 12 plus
//                one wrap bit).
//   bin2gray() : binary to reflected Gray code.
//   gray2bin() : Gray to binary, limited to the low 'width' bits.
//   depth()    : FIFO depth in words for a given address width.
// Instances cast ptr_t results down to their own ASIZE+1 pointer width.
// -----------------------------------------------------------------------------
package fifo_pkg;

    localparam int unsigned MAX_PTR_W = 13;

    typedef logic [MAX_PTR_W-1:0] ptr_t;

    // Bits above the pointer width are zero, so a single shift-xor gives the
    // Gray code for any width.
    function automatic ptr_t bin2gray(input ptr_t bin);
        return bin ^ (bin >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at and above it. Bits at
    // and above 'width' are masked off first so stray upper bits cannot leak in.
    function automatic ptr_t gray2bin(input ptr_t gray, input int unsigned width);
        ptr_t g;
        ptr_t b;
        logic acc;
        g   = gray & ((ptr_t'(1) << width) - ptr_t'(1));
        b   = '0;
        acc = 1'b0;
        for (int i = MAX_PTR_W - 1; i >= 0; i--) begin
            acc  = acc ^ g[i];
            b[i] = acc;
        end
        return b;
    endfunction

    function automatic int unsigned depth(input int unsigned asize);
        return 32'd1 << asize;
    endfunction

endpackage

// File: rtl/wptr_full_lvl_if.sv
// -----------------------------------------------------------------------------
// wptr_full_lvl_if
// Write-side bundle between the write client and the write-pointer block.
//   wrt_en       : write request                       (client -> block)
//   s_rptr       : synchronised Gray read pointer      (client -> block)
//   af_thresh    : almost-full threshold in words      (client -> block)
//   ovf_clr      : clear sticky overflow               (client -> block)
//   wrt_acc      : write accepted (memory write strobe)(block -> client)
//   waddr        : memory write address                (block -> client)
//   wptr         : registered Gray write pointer       (block -> client)
//   wfull        : registered full flag                (block -> client)
//   walmost_full : registered almost-full flag         (block -> client)
//   wlevel       : registered fill level               (block -> client)
//   woverflow    : sticky overflow flag                (block -> client)
// master = write client / environment, slave = wptr_full_lvl.
// -----------------------------------------------------------------------------
interface wptr_full_lvl_if #(
    parameter int ASIZE = 4
) ();

    logic             wrt_en;
    logic [ASIZE:0]   s_rptr;
    logic [ASIZE:0]   af_thresh;
    logic             ovf_clr;
    logic             wrt_acc;
    logic [ASIZE-1:0] waddr;
    logic [ASIZE:0]   wptr;
    logic             wfull;
    logic             walmost_full;
    logic [ASIZE:0]   wlevel;
    logic             woverflow;

    modport master (
        output wrt_en, s_rptr, af_thresh, ovf_clr,
        input  wrt_acc, waddr, wptr, wfull, walmost_full, wlevel, woverflow
    );

    modport slave (
        input  wrt_en, s_rptr, af_thresh, ovf_clr,
        output wrt_acc, waddr, wptr, wfull, walmost_full, wlevel, woverflow
    );

endinterface

// File: rtl/wptr_full_lvl_gray2bin.sv
// -----------------------------------------------------------------------------
// gray2bin_conv
// Purely combinational Gray-to-binary converter (XOR prefix from the MSB).
// Shared with the read-side rptr_empty_lvl block.
//   gray_i : W-bit Gray code input
//   bin_o  : W-bit binary output
// -----------------------------------------------------------------------------
module gray2bin_conv #(
    parameter int W = 5
) (
    input  logic [W-1:0] gray_i,
    output logic [W-1:0] bin_o
);

    generate
        for (genvar gi = 0; gi < W; gi++) begin : g_bit
            assign bin_o[gi] = ^gray_i[W-1:gi];
        end
    endgenerate

endmodule

// File: rtl/wptr_full_lvl.sv
// -----------------------------------------------------------------------------
// wptr_full_lvl
// Write-domain pointer and status block for the dual-clock FIFOs. Keeps the
// binary write address and Gray write pointer, and derives registered full,
// almost-full, fill level and a sticky overflow flag from the read pointer
// already synchronised into the write clock.
//   wrt_clk : write clock
//   wrst    : synchronous active-high reset
//   bus     : wptr_full_lvl_if.slave (request, read pointer, threshold,
//             overflow clear in; accept strobe, address, pointer, status out)
// ASIZE: address width, depth = 2**ASIZE, legal range 1..12.
// Only wrt_en -> wrt_acc is combinational; everything else is registered.
// -----------------------------------------------------------------------------
module wptr_full_lvl
    import fifo_pkg::*;
#(
    parameter int ASIZE = 4
) (
    input  logic           wrt_clk,
    input  logic           wrst,
    wptr_full_lvl_if.slave bus
);

    localparam int unsigned PW = ASIZE + 1;
    localparam int unsigned DEPTH = depth(ASIZE);
    localparam logic [PW-1:0] FULL_LVL = PW'(DEPTH);
    // Gray image of "binary + DEPTH": the two most significant Gray bits flip.
    localparam logic [PW-1:0] FULL_GMASK = PW'(3) << (PW - 2);

    logic [PW-1:0] bin_q,  bin_d;
    logic [PW-1:0] gptr_q, gptr_d;
    logic [PW-1:0] lvl_q,  lvl_d;
    logic          full_q, full_d;
    logic          af_q,   af_d;
    logic          ovf_q,  ovf_d;

    logic [PW-1:0] rbin;
    logic          wrt_acc;
    logic          full_gray;

    gray2bin_conv #(
        .W (PW)
    ) u_rptr_conv (
        .gray_i (bus.s_rptr),
        .bin_o  (rbin)
    );

    always_comb begin
        wrt_acc = bus.wrt_en & ~full_q;
        bin_d   = bin_q + PW'(wrt_acc);
        gptr_d  = PW'(bin2gray(ptr_t'(bin_d)));
        // Modulo-2**PW difference; s_rptr lags the real read pointer, so this
        // can only overestimate the occupancy.
        lvl_d   = bin_d - rbin;
        full_d  = (lvl_d == FULL_LVL);
        af_d    = (lvl_d >= bus.af_thresh);
        // Set term wins over clear when both occur in the same cycle.
        ovf_d   = (ovf_q & ~bus.ovf_clr) | (bus.wrt_en & full_q);
    end

    // Classic Gray-domain full detect, kept as a cross-check on the
    // level-based full so both formulations stay provably identical.
    always_comb begin
        full_gray = (gptr_d == (bus.s_rptr ^ FULL_GMASK));
        assert (full_gray == full_d);
        assert (rbin == PW'(gray2bin(ptr_t'(bus.s_rptr), PW)));
    end

    always_ff @(posedge wrt_clk) begin
        if (wrst) begin
            bin_q  <= '0;
            gptr_q <= '0;
            lvl_q  <= '0;
            full_q <= 1'b0;
            af_q   <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            gptr_q <= gptr_d;
            lvl_q  <= lvl_d;
            full_q <= full_d;
            af_q   <= af_d;
            ovf_q  <= ovf_d;
        end
    end

    assign bus.wrt_acc      = wrt_acc;
    assign bus.waddr        = bin_q[ASIZE-1:0];
    assign bus.wptr         = gptr_q;
    assign bus.wfull        = full_q;
    assign bus.walmost_full = af_q;
    assign bus.wlevel       = lvl_q;
    assign bus.woverflow    = ovf_q;

endmodule

// File: tb/tb_wptr_full_lvl.sv
// -----------------------------------------------------------------------------
// tb_wptr_full_lvl
// Directed bench for wptr_full_lvl with ASIZE=4 (depth 16).
// -----------------------------------------------------------------------------
module tb_wptr_full_lvl;

    logic clk = 1'b0;
    logic wrst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   txn_n = 0;

    always #5 clk = ~clk;

    wptr_full_lvl_if #(.ASIZE(4)) bus ();

    wptr_full_lvl #(.ASIZE(4)) dut (
        .wrt_clk (clk),
        .wrst    (wrst),
        .bus     (bus)
    );

    function automatic logic [4:0] g5(input int b);
        logic [4:0] x;
        x = 5'(b);
        return x ^ (x >> 1);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        txn_n++;
        $display("txn %0d: wrst=%0b wen=%0b clr=%0b s_rptr=%b thr=%0d -> waddr=%0d wptr=%b lvl=%0d full=%0b af=%0b ovf=%0b",
                 txn_n, wrst, bus.wrt_en, bus.ovf_clr, bus.s_rptr, bus.af_thresh,
                 bus.waddr, bus.wptr, bus.wlevel, bus.wfull, bus.walmost_full, bus.woverflow);
    endtask

    task automatic test_reset();
        wrst = 1'b1;
        bus.wrt_en = 1'b0; bus.s_rptr = '0; bus.af_thresh = '0; bus.ovf_clr = 1'b0;
        tick(); tick();
        checks++; if (bus.waddr !== 4'd0) begin errors++; $display("FAIL reset_waddr got=%0d exp=0", bus.waddr); end
        checks++; if (bus.wptr !== 5'd0) begin errors++; $display("FAIL reset_wptr got=%b exp=00000", bus.wptr); end
        checks++; if (bus.wlevel !== 5'd0) begin errors++; $display("FAIL reset_wlevel got=%0d exp=0", bus.wlevel); end
        checks++; if (bus.wfull !== 1'b0) begin errors++; $display("FAIL reset_wfull got=%0b exp=0", bus.wfull); end
        checks++; if (bus.walmost_full !== 1'b0) begin errors++; $display("FAIL reset_af got=%0b exp=0", bus.walmost_full); end
        checks++; if (bus.woverflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%0b exp=0", bus.woverflow); end
        wrst = 1'b0;
        bus.wrt_en = 1'b1;
        #1;
        checks++; if (bus.wrt_acc !== 1'b1) begin errors++; $display("FAIL reset_acc got=%0b exp=1", bus.wrt_acc); end
        bus.wrt_en = 1'b0;
        // Threshold 0: flag is 1 after the first post-reset edge.
        tick();
        checks++; if (bus.walmost_full !== 1'b1) begin errors++; $display("FAIL af_zero got=%0b exp=1", bus.walmost_full); end
        checks++; if (bus.wlevel !== 5'd0) begin errors++; $display("FAIL af_zero_lvl got=%0d exp=0", bus.wlevel); end
        wrst = 1'b1;
        tick();
        wrst = 1'b0;
    endtask

    task automatic test_fill();
        bus.af_thresh = 5'd12;
        bus.s_rptr = '0;
        for (int i = 1; i <= 16; i++) begin
            bus.wrt_en = 1'b1;
            #1;
            checks++; if (bus.wrt_acc !== 1'b1) begin errors++; $display("FAIL fill_acc[%0d] got=%0b exp=1", i, bus.wrt_acc); end
            tick();
            checks++; if (bus.wlevel !== 5'(i)) begin errors++; $display("FAIL fill_lvl[%0d] got=%0d exp=%0d", i, bus.wlevel, i); end
            checks++; if (bus.waddr !== 4'(i % 16)) begin errors++; $display("FAIL fill_waddr[%0d] got=%0d exp=%0d", i, bus.waddr, i % 16); end
            checks++; if (bus.wfull !== (i == 16)) begin errors++; $display("FAIL fill_full[%0d] got=%0b exp=%0b", i, bus.wfull, (i == 16)); end
            checks++; if (bus.walmost_full !== (i >= 12)) begin errors++; $display("FAIL fill_af[%0d] got=%0b exp=%0b", i, bus.walmost_full, (i >= 12)); end
            if (i == 12) begin
                bus.wrt_en = 1'b0;
                bus.af_thresh = 5'd13;
                tick();
                checks++; if (bus.walmost_full !== 1'b0) begin errors++; $display("FAIL af_thr13 got=%0b exp=0", bus.walmost_full); end
                checks++; if (bus.wlevel !== 5'd12) begin errors++; $display("FAIL af_thr13_lvl got=%0d exp=12", bus.wlevel); end
                bus.af_thresh = 5'd12;
            end
        end
        checks++; if (bus.wptr !== 5'b11000) begin errors++; $display("FAIL fill_wptr got=%b exp=11000", bus.wptr); end
        checks++; if (bus.woverflow !== 1'b0) begin errors++; $display("FAIL fill_ovf got=%0b exp=0", bus.woverflow); end
        #1;
        checks++; if (bus.wrt_acc !== 1'b0) begin errors++; $display("FAIL full_acc got=%0b exp=0", bus.wrt_acc); end
    endtask

    task automatic test_overflow();
        bus.wrt_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (bus.woverflow !== 1'b1) begin errors++; $display("FAIL ovf_set[%0d] got=%0b exp=1", k, bus.woverflow); end
            checks++; if (bus.wptr !== 5'b11000) begin errors++; $display("FAIL ovf_wptr[%0d] got=%b exp=11000", k, bus.wptr); end
            checks++; if (bus.waddr !== 4'd0) begin errors++; $display("FAIL ovf_waddr[%0d] got=%0d exp=0", k, bus.waddr); end
            checks++; if (bus.wlevel !== 5'd16) begin errors++; $display("FAIL ovf_lvl[%0d] got=%0d exp=16", k, bus.wlevel); end
        end
        bus.wrt_en = 1'b0; bus.ovf_clr = 1'b1;
        tick();
        checks++; if (bus.woverflow !== 1'b0) begin errors++; $display("FAIL ovf_clr got=%0b exp=0", bus.woverflow); end
        bus.wrt_en = 1'b1; bus.ovf_clr = 1'b1;
        tick();
        checks++; if (bus.woverflow !== 1'b1) begin errors++; $display("FAIL ovf_set_wins got=%0b exp=1", bus.woverflow); end
        bus.wrt_en = 1'b0; bus.ovf_clr = 1'b0;
        tick();
        checks++; if (bus.woverflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%0b exp=1", bus.woverflow); end
        bus.ovf_clr = 1'b1;
        tick();
        checks++; if (bus.woverflow !== 1'b0) begin errors++; $display("FAIL ovf_clr2 got=%0b exp=0", bus.woverflow); end
        bus.ovf_clr = 1'b0;
        // Threshold equal to depth tracks wfull.
        bus.af_thresh = 5'd16;
        tick();
        checks++; if (bus.walmost_full !== 1'b1) begin errors++; $display("FAIL af_thr16 got=%0b exp=1", bus.walmost_full); end
        bus.af_thresh = 5'd12;
    endtask

    task automatic test_read_release();
        bus.s_rptr = 5'b00110;
        tick();
        checks++; if (bus.wfull !== 1'b0) begin errors++; $display("FAIL rel_full got=%0b exp=0", bus.wfull); end
        checks++; if (bus.wlevel !== 5'd12) begin errors++; $display("FAIL rel_lvl got=%0d exp=12", bus.wlevel); end
        checks++; if (bus.walmost_full !== 1'b1) begin errors++; $display("FAIL rel_af got=%0b exp=1", bus.walmost_full); end
        bus.wrt_en = 1'b1;
        #1;
        checks++; if (bus.wrt_acc !== 1'b1) begin errors++; $display("FAIL rel_acc got=%0b exp=1", bus.wrt_acc); end
    endtask

    task automatic test_back_to_back();
        bus.wrt_en = 1'b1;
        bus.s_rptr = 5'b00111;
        tick();
        checks++; if (bus.wlevel !== 5'd12) begin errors++; $display("FAIL b2b_lvl got=%0d exp=12", bus.wlevel); end
        checks++; if (bus.waddr !== 4'd1) begin errors++; $display("FAIL b2b_waddr got=%0d exp=1", bus.waddr); end
        checks++; if (bus.wptr !== 5'b11001) begin errors++; $display("FAIL b2b_wptr got=%b exp=11001", bus.wptr); end
        checks++; if (bus.wfull !== 1'b0) begin errors++; $display("FAIL b2b_full got=%0b exp=0", bus.wfull); end
    endtask

    task automatic test_wrap();
        int lvl_e;
        // bin 17 -> 32 (wraps to 0) with the read pointer trailing by 12.
        for (int b = 18; b <= 32; b++) begin
            bus.wrt_en = 1'b1;
            bus.s_rptr = g5(b - 12);
            tick();
            checks++; if (bus.wlevel !== 5'd12) begin errors++; $display("FAIL wrap_lvl[%0d] got=%0d exp=12", b, bus.wlevel); end
            checks++; if (bus.waddr !== 4'(b % 16)) begin errors++; $display("FAIL wrap_waddr[%0d] got=%0d exp=%0d", b, bus.waddr, b % 16); end
            checks++; if (bus.wfull !== 1'b0) begin errors++; $display("FAIL wrap_full[%0d] got=%0b exp=0", b, bus.wfull); end
        end
        checks++; if (bus.wptr !== 5'b00000) begin errors++; $display("FAIL wrap_wptr got=%b exp=00000", bus.wptr); end
        bus.wrt_en = 1'b0;
        // Write pointer parked at 0; sweep every read pointer value.
        for (int r = 0; r < 32; r++) begin
            bus.s_rptr = g5(r);
            tick();
            lvl_e = (32 - r) % 32;
            checks++; if (bus.wlevel !== 5'(lvl_e)) begin errors++; $display("FAIL sweep_lvl[%0d] got=%0d exp=%0d", r, bus.wlevel, lvl_e); end
            checks++; if (bus.wfull !== (lvl_e == 16)) begin errors++; $display("FAIL sweep_full[%0d] got=%0b exp=%0b", r, bus.wfull, (lvl_e == 16)); end
        end
    endtask

    task automatic test_reset_mid();
        wrst = 1'b1;
        tick();
        wrst = 1'b0;
        bus.s_rptr = '0; bus.af_thresh = 5'd12; bus.ovf_clr = 1'b0;
        bus.wrt_en = 1'b1;
        for (int k = 0; k < 17; k++) tick();
        bus.wrt_en = 1'b0;
        for (int r = 1; r <= 7; r++) begin
            bus.s_rptr = g5(r);
            tick();
        end
        checks++; if (bus.wlevel !== 5'd9) begin errors++; $display("FAIL mid_pre_lvl got=%0d exp=9", bus.wlevel); end
        checks++; if (bus.woverflow !== 1'b1) begin errors++; $display("FAIL mid_pre_ovf got=%0b exp=1", bus.woverflow); end
        wrst = 1'b1;
        bus.wrt_en = 1'b1;
        tick();
        checks++; if (bus.waddr !== 4'd0) begin errors++; $display("FAIL mid_waddr got=%0d exp=0", bus.waddr); end
        checks++; if (bus.wptr !== 5'd0) begin errors++; $display("FAIL mid_wptr got=%b exp=00000", bus.wptr); end
        checks++; if (bus.wlevel !== 5'd0) begin errors++; $display("FAIL mid_lvl got=%0d exp=0", bus.wlevel); end
        checks++; if (bus.wfull !== 1'b0) begin errors++; $display("FAIL mid_full got=%0b exp=0", bus.wfull); end
        checks++; if (bus.walmost_full !== 1'b0) begin errors++; $display("FAIL mid_af got=%0b exp=0", bus.walmost_full); end
        checks++; if (bus.woverflow !== 1'b0) begin errors++; $display("FAIL mid_ovf got=%0b exp=0", bus.woverflow); end
        wrst = 1'b0;
        #1;
        checks++; if (bus.wrt_acc !== 1'b1) begin errors++; $display("FAIL mid_acc got=%0b exp=1", bus.wrt_acc); end
        bus.wrt_en = 1'b0;
    endtask

    initial begin
        bus.wrt_en = 1'b0;
        bus.s_rptr = '0;
        bus.af_thresh = '0;
        bus.ovf_clr = 1'b0;
        test_reset();
        test_fill();
        test_overflow();
        test_read_release();
        test_back_to_back();
        test_wrap();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
